// File: rtl/pipe_stage_elastic_reg.sv
// Generic elastic pipeline stage: data + control payload under valid/ready.
// SKID=0 gives a single entry with a combinational in_ready.
// SKID=1 gives a head + skid pair with a registered in_ready, so the
// stage runs at full throughput without a combinational path from
// out_ready back to in_ready.
// flush empties the stage and kills any input handshaking in the same cycle.
// stall_cnt counts back-pressured cycles for hazard-unit debug.
module pipe_stage_elastic_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State value equals the number of held entries.
    // With SKID=0, ST_TWO is never reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  head_data_q, head_data_d;
    logic [CTRL_W-1:0]  head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               in_fire;
    logic               out_fire;

    // State, payload and counter registers; reset empties the stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state and payload movement; flush overrides every other event.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            head_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        // Head leaves and the new word takes its place.
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end else if (in_fire && (SKID != 0)) begin
                        // Downstream stalled: park the new word behind the head.
                        state_d     = ST_TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        head_data_d = skid_data_q;
                        head_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        // The registered ready simply mirrors "not full" for the next cycle.
        in_ready_d = (state_d != ST_TWO);
    end

    // Saturating count of cycles in which a valid head was back-pressured.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Outputs and handshake decode; control is gated so bubbles never write.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        if (SKID != 0) begin
            in_ready = in_ready_q;
        end else begin
            in_ready = !out_valid || out_ready;
        end
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        out_data  = head_data_q;
        out_ctrl  = out_valid ? head_ctrl_q : '0;
        occupancy = state_q;
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: doc/pipe_stage_elastic_reg.md
Name: pipe_stage_elastic_reg

Overview:
Parametrised successor to the fixed-field inter-stage pipeline registers; one generic elastic stage usable between any two pipeline stages (IF/ID through MEM/WB).
Carries an opaque data word plus a control word under a valid/ready handshake.
Supports flush (bubble insertion) and an optional two-entry skid mode giving full throughput with a registered upstream ready.
Exposes occupancy and a saturating back-pressure counter for hazard-unit debug.

Parameters:
DATA_W, 32, width of datapath payload (alu_out, dmem_out, pc4, etc. concatenated by instantiator)
CTRL_W, 8, width of control payload (rf_wena, rf_waddr, mux selects); forced to 0 when the entry is invalid
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (stage empties when rst=0)
in_valid  in  1  upstream has a stage payload
in_ready  out  1  stage can accept; transfer when in_valid && in_ready
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
flush  in  1  synchronous kill of all held entries and of any same-cycle input
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
out_data  out  DATA_W  head-entry data
out_ctrl  out  CTRL_W  head-entry control; 0 whenever out_valid=0
occupancy  out  2  number of held entries (0..1 for SKID=0, 0..2 for SKID=1)
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Reset (rst=0, async): all valid bits 0, out_data 0, out_ctrl 0, occupancy 0, stall_cnt 0; in_ready 1 in both modes. Reset mid-transfer discards all entries; no partial state survives.
- Latency: an input accepted at edge N drives out_valid=1 with that payload after edge N. Strict FIFO ordering; no payload dropped or duplicated except by flush.
- SKID=0: states EMPTY, FULL. in_ready = !out_valid || out_ready (combinational). EMPTY + in transfer -> FULL. FULL + out transfer with no in transfer -> EMPTY. Simultaneous in and out transfers -> stays FULL, head replaced by new input.
- SKID=1: states EMPTY, ONE, TWO (head reg + skid reg). in_ready = (state != TWO), registered (no combinational path from out_ready).
  EMPTY + in -> ONE.
  ONE + in, no out -> TWO (input into skid).
  ONE + in + out -> ONE (input into head).
  ONE + out only -> EMPTY.
  TWO + out -> ONE (skid moves to head); no input is accepted in TWO.
- Flush (sampled at edge): next state EMPTY, all valid bits 0, out_ctrl 0; any input handshaking in the same cycle is discarded. Flush overrides every simultaneous event. Data registers may retain stale values; out_data is don't-care while out_valid=0.
- out_ctrl is gated to 0 when out_valid=0, so downstream write enables never fire on a bubble.
- occupancy = number of valid entries, updated at the same edge as the state.
- stall_cnt: +1 on each edge where out_valid && !out_ready was true in the preceding cycle; holds at 2^CNT_W-1 (no wrap); not cleared by flush; cleared only by reset.
- Payload width: in_data/in_ctrl are stored verbatim; no arithmetic is performed on them.

Test Plan:
- Reset: drive rst=0 mid-stream with occupancy=2 -> immediately out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0, in_ready=1.
- Streaming (SKID=1): in_valid=1 every cycle, data 0x1..0x10, out_ready=1 -> out_valid from cycle 2, outputs 0x1..0x10 in order at one per cycle, occupancy stays 1.
- Back-pressure: send 0xA, 0xB, 0xC with out_ready=0 -> occupancy 2 and in_ready=0 after 0xB; 0xC is held upstream; release out_ready -> outputs 0xA, 0xB, 0xC in order; stall_cnt equals the number of cycles with out_valid && !out_ready.
- Flush: occupancy=2 with in_valid=1 and flush=1 in the same cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed input never appears on the output.
- SKID=0 simultaneous transfer: FULL with 0x5 held, in 0x6 and out_ready=1 in the same cycle -> 0x5 is delivered, 0x6 is held, occupancy stays 1.
- Saturation (CNT_W=4): hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
